// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- 5-stage pipeline hazard / stall controller.
//
// Generates the advance enables and bubble (flush) controls for the PC,
// IF/ID and ID/EX registers. It handles three cases:
//   * load-use hazards: one-cycle bubble into EX while IF/ID holds.
//   * taken branches: squash both younger stages.
//   * multi-cycle mul/div ops: freeze the front end while EX is busy.
// It also keeps a saturating count of front-end stall cycles.
//
// Parameters
//   MUL_LAT   cycles a mul/div op occupies EX (2..15)
//   CNT_W     width of StallCount
// Ports
//   Clk, Rst                  clock, synchronous active-high reset
//   IdValid, IdRs, IdRt,
//   IdUsesRs, IdUsesRt,
//   IdMulDiv                  decoded ID-stage instruction info
//   ExRd, ExRegWrite,
//   ExMemRead                 EX-stage destination / write / load info
//   BranchTaken               EX resolved a taken branch/jump
//   PcEn, IfIdEn, IdExEn      register advance enables
//   IfIdFlush, IdExFlush      load a bubble into that register
//   MulBusy                   multi-cycle op occupying EX
//   StallCount                cycles with PcEn=0 since reset (saturating)
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IdValid,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             IdUsesRs,
    input  logic             IdUsesRt,
    input  logic             IdMulDiv,
    input  logic [4:0]       ExRd,
    input  logic             ExRegWrite,
    input  logic             ExMemRead,
    input  logic             BranchTaken,
    output logic             PcEn,
    output logic             IfIdEn,
    output logic             IdExEn,
    output logic             IfIdFlush,
    output logic             IdExFlush,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {RUN = 1'b0, MUL = 1'b1} state_e;

    // First MUL cycle already counts, so MUL lasts MUL_LAT-1 cycles.
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_hit, rt_hit, hazard;

    // Load-use hazard; r0 is never a real dependency.
    assign rs_hit = IdUsesRs && (IdRs == ExRd);
    assign rt_hit = IdUsesRt && (IdRt == ExRd);
    assign hazard = IdValid && ExMemRead && ExRegWrite && (ExRd != 5'd0)
                    && (rs_hit || rt_hit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        PcEn      = 1'b1;
        IfIdEn    = 1'b1;
        IdExEn    = 1'b1;
        IfIdFlush = 1'b0;
        IdExFlush = 1'b0;
        MulBusy   = 1'b0;
        if (Rst) begin
            state_d   = RUN;
            cnt_d     = 4'd0;
            PcEn      = 1'b0;
            IfIdEn    = 1'b0;
            IdExEn    = 1'b0;
            IfIdFlush = 1'b1;
            IdExFlush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (BranchTaken) begin
                        // Branch wins over hazard and mul entry: the ID
                        // instruction is squashed anyway.
                        IfIdFlush = 1'b1;
                        IdExFlush = 1'b1;
                    end else if (hazard) begin
                        PcEn      = 1'b0;
                        IfIdEn    = 1'b0;
                        IdExFlush = 1'b1;
                    end else if (IdValid && IdMulDiv) begin
                        state_d = MUL;
                        cnt_d   = MUL_INIT;
                    end
                end
                MUL: begin
                    // EX holds the mul/div; branch and hazard inputs
                    // are stale here and deliberately ignored.
                    PcEn    = 1'b0;
                    IfIdEn  = 1'b0;
                    IdExEn  = 1'b0;
                    MulBusy = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Rst)
            stall_cnt_d = '0;
        else if (!PcEn && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Two instances share stimulus: the
// default configuration and a CNT_W=4 copy for counter saturation.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_pipe_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IdValid, IdUsesRs, IdUsesRt, IdMulDiv;
    logic [4:0]  IdRs, IdRt, ExRd;
    logic        ExRegWrite, ExMemRead, BranchTaken;

    logic        PcEn, IfIdEn, IdExEn, IfIdFlush, IdExFlush, MulBusy;
    logic [15:0] StallCount;
    logic        PcEn4, IfIdEn4, IdExEn4, IfIdFlush4, IdExFlush4, MulBusy4;
    logic [3:0]  StallCount4;

    logic [5:0]  ctl, ctl4;
    assign ctl  = {PcEn,  IfIdEn,  IdExEn,  IfIdFlush,  IdExFlush,  MulBusy};
    assign ctl4 = {PcEn4, IfIdEn4, IdExEn4, IfIdFlush4, IdExFlush4, MulBusy4};

    // {PcEn, IfIdEn, IdExEn, IfIdFlush, IdExFlush, MulBusy}
    localparam logic [5:0] C_RUN = 6'b111000;
    localparam logic [5:0] C_HAZ = 6'b001010;
    localparam logic [5:0] C_BR  = 6'b111110;
    localparam logic [5:0] C_MUL = 6'b000001;
    localparam logic [5:0] C_RST = 6'b000110;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    pipe_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
        .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .IdMulDiv(IdMulDiv),
        .ExRd(ExRd), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .BranchTaken(BranchTaken), .PcEn(PcEn), .IfIdEn(IfIdEn),
        .IdExEn(IdExEn), .IfIdFlush(IfIdFlush), .IdExFlush(IdExFlush),
        .MulBusy(MulBusy), .StallCount(StallCount)
    );

    pipe_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
        .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .IdMulDiv(IdMulDiv),
        .ExRd(ExRd), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .BranchTaken(BranchTaken), .PcEn(PcEn4), .IfIdEn(IfIdEn4),
        .IdExEn(IdExEn4), .IfIdFlush(IfIdFlush4), .IdExFlush(IdExFlush4),
        .MulBusy(MulBusy4), .StallCount(StallCount4)
    );

    task automatic set_idle();
        Rst = 1'b0; IdValid = 1'b0; IdUsesRs = 1'b0; IdUsesRt = 1'b0;
        IdMulDiv = 1'b0; IdRs = 5'd0; IdRt = 5'd0; ExRd = 5'd0;
        ExRegWrite = 1'b0; ExMemRead = 1'b0; BranchTaken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk); #1;
        set_idle();
    endtask

    task automatic set_load_use(input logic [4:0] r);
        IdValid = 1'b1; IdUsesRs = 1'b1; IdRs = r; ExRd = r;
        ExRegWrite = 1'b1; ExMemRead = 1'b1;
    endtask

    task automatic push_exp(input logic [5:0] c, input int n);
        exp_t x;
        x.ctl  = c;
        x.cnt  = 16'(n);
        x.cnt4 = (n > 15) ? 4'd15 : 4'(n);
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        next_cycle(); Rst = 1'b1;
        next_cycle(); Rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); Rst = 1'b1;
            // Reset dominates a simultaneous mul / hazard request.
            if (i == 1) begin set_load_use(5'd3); IdMulDiv = 1'b1; end
            push_exp(C_RST, 0);
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || ctl4 !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL reset c%0d ctl=%b/%b cnt=%0d/%0d expected ctl=%b cnt=%0d/%0d",
                         i, ctl, ctl4, StallCount, StallCount4, e.ctl, e.cnt, e.cnt4);
            end
        end
        next_cycle();
        push_exp(C_RUN, 0);
        @(negedge Clk); e = exp_q.pop_front(); checks++;
        if (ctl !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
            failures++;
            $display("FAIL reset_release ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                     ctl, StallCount, e.ctl, e.cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            case (i)
                0: begin set_load_use(5'd5); push_exp(C_HAZ, 0); end
                1: push_exp(C_RUN, 1);
                2: begin IdValid = 1'b1; IdUsesRt = 1'b1; IdRt = 5'd7; ExRd = 5'd7;
                         ExRegWrite = 1'b1; ExMemRead = 1'b1; push_exp(C_HAZ, 1); end
                3: begin IdValid = 1'b1; IdUsesRt = 1'b0; IdRt = 5'd7; ExRd = 5'd7;
                         ExRegWrite = 1'b1; ExMemRead = 1'b1; push_exp(C_RUN, 2); end
                4: begin set_load_use(5'd9); ExRegWrite = 1'b0; push_exp(C_RUN, 2); end
                5: begin set_load_use(5'd9); IdValid = 1'b0; push_exp(C_RUN, 2); end
                default: begin set_load_use(5'd9); ExMemRead = 1'b0; push_exp(C_RUN, 2); end
            endcase
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL load_use c%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, StallCount, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            if (i == 0) set_load_use(5'd0);
            push_exp(C_RUN, 0);
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL zero_reg c%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, StallCount, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_mul();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            case (i)
                0: begin IdValid = 1'b1; IdMulDiv = 1'b1; push_exp(C_RUN, 0); end
                // Branch and load-use during MUL must not disturb it.
                2: begin set_load_use(5'd4); BranchTaken = 1'b1; push_exp(C_MUL, 1); end
                4: push_exp(C_RUN, 3);
                default: push_exp(C_MUL, i - 1);
            endcase
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || ctl4 !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL mul c%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, StallCount, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            if (i <= 4) begin IdValid = 1'b1; IdMulDiv = 1'b1; end
            case (i)
                0: push_exp(C_RUN, 0);
                1, 2, 3: push_exp(C_MUL, i - 1);
                4: push_exp(C_RUN, 3);
                5, 6, 7: push_exp(C_MUL, i - 2);
                default: push_exp(C_RUN, 6);
            endcase
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL back_to_back c%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, StallCount, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            case (i)
                0: begin set_load_use(5'd6); BranchTaken = 1'b1; push_exp(C_BR, 0); end
                1: begin IdValid = 1'b1; IdMulDiv = 1'b1; BranchTaken = 1'b1; push_exp(C_BR, 0); end
                default: push_exp(C_RUN, 0);
            endcase
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL branch c%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, StallCount, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            case (i)
                0: begin IdValid = 1'b1; IdMulDiv = 1'b1; push_exp(C_RUN, 0); end
                1: push_exp(C_MUL, 0);
                2: begin Rst = 1'b1; push_exp(C_RST, 1); end
                3: begin Rst = 1'b1; push_exp(C_RST, 0); end
                default: push_exp(C_RUN, 0);
            endcase
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL reset_mid_mul c%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, StallCount, e.ctl, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            next_cycle();
            if (i < 20) begin set_load_use(5'd12); push_exp(C_HAZ, i); end
            else push_exp(C_RUN, 20);
            @(negedge Clk); e = exp_q.pop_front(); checks++;
            if (ctl4 !== e.ctl || StallCount !== e.cnt || StallCount4 !== e.cnt4) begin
                failures++;
                $display("FAIL saturation c%0d ctl4=%b cnt=%0d cnt4=%0d expected ctl=%b cnt=%0d cnt4=%0d",
                         i, ctl4, StallCount, StallCount4, e.ctl, e.cnt, e.cnt4);
            end
        end
    endtask

    initial begin
        set_idle();
        Rst = 1'b1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_mul();
        test_back_to_back();
        test_branch();
        test_reset_mid_mul();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MUL_LAT, default 4, number of cycles a multi-cycle (mul/div) op occupies EX; legal range 2..15.
REQ-002 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  in  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 IdValid  in  1  ID stage holds a real instruction.
REQ-006 IdRs, IdRt  in  5 each  ID source register numbers.
REQ-007 IdUsesRs, IdUsesRt  in  1 each  ID instruction reads that source.
REQ-008 IdMulDiv  in  1  ID instruction is a multi-cycle op.
REQ-009 ExRd  in  5  EX destination register.
REQ-010 ExRegWrite, ExMemRead  in  1 each  EX instruction writes a register / is a load.
REQ-011 BranchTaken  in  1  EX resolved a taken branch or jump this cycle.
REQ-012 PcEn, IfIdEn, IdExEn  out  1 each  advance enable for PC, IF/ID and ID/EX registers.
REQ-013 IfIdFlush, IdExFlush  out  1 each  load all-zero bubble into that register this cycle.
REQ-014 MulBusy  out  1  multi-cycle op occupying EX.
REQ-015 StallCount  out  CNT_W  number of cycles with PcEn=0 since reset.

Function
REQ-016 States: RUN, MUL; state and a 4-bit down-counter Cnt are the only control registers.
REQ-017 Hazard H = IdValid & ExMemRead & ExRegWrite & ExRd!=0 & ((IdUsesRs & IdRs==ExRd) | (IdUsesRt & IdRt==ExRd)).
REQ-018 ExRd==0 never produces H.
REQ-019 RUN, BranchTaken=1: PcEn=1, IfIdEn=1, IdExEn=1, IfIdFlush=1, IdExFlush=1; H and IdMulDiv ignored; stay RUN.
REQ-020 RUN, BranchTaken=0, H=1: PcEn=0, IfIdEn=0, IdExEn=1, IdExFlush=1, IfIdFlush=0; stay RUN (one-cycle bubble; H clears once load leaves EX).
REQ-021 RUN, BranchTaken=0, H=0, IdValid&IdMulDiv=1: all enables 1, no flush; next state MUL, Cnt <= MUL_LAT-1.
REQ-022 RUN, otherwise: all enables 1, both flushes 0.
REQ-023 MUL: PcEn=0, IfIdEn=0, IdExEn=0, flushes 0, MulBusy=1; Cnt decrements each cycle; when Cnt==1 next state RUN.
REQ-024 MUL: BranchTaken and H are ignored (EX holds the multi-cycle op).
REQ-025 MulBusy=1 exactly in MUL; multi-cycle op therefore stalls front end MUL_LAT-1 cycles.
REQ-026 All outputs other than StallCount are combinational from state, Cnt and inputs; no output latency beyond that.
REQ-027 StallCount increments by 1 every non-reset cycle in which PcEn=0; saturates at all-ones, no wrap.
REQ-028 Back-to-back multi-cycle ops: second op in ID when MUL exits re-enters MUL the following RUN cycle if H=0.

Reset
REQ-029 Rst=1 at posedge: state <= RUN, Cnt <= 0, StallCount <= 0, regardless of current state (including mid-MUL).
REQ-030 While Rst=1: PcEn=IfIdEn=IdExEn=0, IfIdFlush=IdExFlush=1, MulBusy=0.
REQ-031 First cycle after Rst deasserts behaves as RUN with empty history.

Verification
REQ-032 Load-use: ExMemRead=1, ExRegWrite=1, ExRd=5, IdRs=5, IdUsesRs=1, IdValid=1 -> one cycle PcEn=0, IfIdEn=0, IdExFlush=1; StallCount 0->1.
REQ-033 Zero register: same as REQ-032 with ExRd=0, IdRs=0 -> PcEn=1, no flush, StallCount unchanged.
REQ-034 Multiply, MUL_LAT=4: IdMulDiv=1 in RUN -> MulBusy=1 for exactly 3 cycles, PcEn=0 those 3 cycles, StallCount=3, then RUN.
REQ-035 Branch vs hazard: BranchTaken=1 and H=1 same cycle -> IfIdFlush=1, IdExFlush=1, PcEn=1, StallCount unchanged.
REQ-036 Reset mid-MUL: Rst=1 on 2nd MUL cycle -> next cycle state RUN, MulBusy=0, StallCount=0, flushes=1 while Rst held.
REQ-037 Saturation, CNT_W=4: hold H stall condition 20 cycles -> StallCount stops at 15.
